// File: rtl/pool_ctrl.sv
// APB-programmed sequencer for the pooling datapath: job configuration,
// four-phase start/done handshake with the datapath, and job latency counter.
module pool_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        pool_start,
  input  logic        pool_done,
  output logic [7:0]  cfg_width,
  output logic [7:0]  cfg_channel,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_CFG    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_CYCLES = ADDR_W'(32'h0C);

  state_t             state, state_nxt;
  logic               start_acc;
  logic               done;
  logic               cfg_rejected;
  logic [CNT_W-1:0]   cycles;

  logic [ADDR_W-1:0]  addr;
  logic               access, wr_en, rd_en;
  logic               sel_ctrl, sel_status, sel_cfg, sel_cycles, mapped;
  logic               start_wr, clr_wr;

  // Upper address and data bits are deliberately not decoded.
  generate
    if (ADDR_W < 32) begin : g_unused_addr
      logic unused_addr;
      assign unused_addr = ^PADDR[31:ADDR_W];
    end
  endgenerate
  logic unused_wdata;
  assign unused_wdata = ^PWDATA[31:16];

  assign addr       = PADDR[ADDR_W-1:0];
  assign access     = PSEL & PENABLE;
  assign wr_en      = access & PWRITE;
  assign rd_en      = access & ~PWRITE;
  assign sel_ctrl   = (addr == OFF_CTRL);
  assign sel_status = (addr == OFF_STATUS);
  assign sel_cfg    = (addr == OFF_CFG);
  assign sel_cycles = (addr == OFF_CYCLES);
  assign mapped     = sel_ctrl | sel_status | sel_cfg | sel_cycles;
  assign start_wr   = wr_en & sel_ctrl & PWDATA[0];
  assign clr_wr     = wr_en & sel_ctrl & PWDATA[1];

  assign PREADY     = 1'b1;
  assign PSLVERR    = access & ~mapped;
  // Decoded from the state register so reset drops the request asynchronously.
  assign pool_start = (state == S_RUN);
  assign busy       = (state == S_RUN) || (state == S_ACK);
  assign done       = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_wr) begin
          state_nxt = S_RUN;
          start_acc = 1'b1;
        end
      end
      S_RUN:  if (pool_done)  state_nxt = S_ACK;
      S_ACK:  if (!pool_done) state_nxt = S_DONE;
      S_DONE: begin
        if (start_wr) begin
          state_nxt = S_RUN;
          start_acc = 1'b1;
        end else if (clr_wr) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latency counter: restarts on an accepted start, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycles <= '0;
    end else if (start_acc) begin
      cycles <= '0;
    end else if (busy && (cycles != {CNT_W{1'b1}})) begin
      cycles <= cycles + CNT_W'(1);
    end
  end

  // Configuration is frozen while a job is in flight; blocked writes are flagged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_width    <= 8'd0;
      cfg_channel  <= 8'd0;
      cfg_rejected <= 1'b0;
    end else begin
      if (wr_en && sel_cfg) begin
        if (busy) begin
          cfg_rejected <= 1'b1;
        end else begin
          cfg_width   <= PWDATA[7:0];
          cfg_channel <= PWDATA[15:8];
        end
      end
      if (clr_wr) cfg_rejected <= 1'b0;
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (rd_en) begin
      if (sel_status)      PRDATA = {29'd0, cfg_rejected, done, busy};
      else if (sel_cfg)    PRDATA = {16'd0, cfg_channel, cfg_width};
      else if (sel_cycles) PRDATA = 32'(cycles);
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: APB master tasks, an auto-responding
// datapath model and expectations derived from job timing parameters.
module tb_pool_ctrl;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk, rstn;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic        pool_start, pool_done, busy;
  logic [7:0]  cfg_width, cfg_channel;
  logic        dp_done, man_done;

  assign pool_done = dp_done | man_done;

  pool_ctrl #(.ADDR_W(16), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .pool_start (pool_start),
    .pool_done  (pool_done),
    .cfg_width  (cfg_width),
    .cfg_channel(cfg_channel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Datapath model: raise done dly_hi cycles after pool_start rises, drop it
  // dly_lo cycles after pool_start falls.
  int dly_hi = 0, dly_lo = 0;
  initial begin
    int hi_n, lo_n;
    bit phase;
    dp_done = 1'b0; phase = 1'b0; hi_n = 0; lo_n = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        dp_done = 1'b0; phase = 1'b0; hi_n = 0; lo_n = 0;
      end else if (!phase) begin
        if (pool_start) begin
          hi_n++;
          if (hi_n == dly_hi + 1) begin dp_done = 1'b1; phase = 1'b1; lo_n = 0; end
        end
      end else if (!pool_start) begin
        lo_n++;
        if (lo_n == dly_lo + 1) begin dp_done = 1'b0; phase = 1'b0; hi_n = 0; end
      end
    end
  end

  // Counts cycles with pool_start high and its rising edges.
  int   start_hi_cyc = 0, start_rises = 0;
  logic ps_q = 1'b0;
  always @(posedge clk) begin
    if (pool_start) start_hi_cyc++;
    if (pool_start && !ps_q) start_rises++;
    ps_q = pool_start;
  end

  // APB tasks are entered and left on a falling clock edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk); PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk); PENABLE = 1'b1;
    #1 begin d = PRDATA; err = PSLVERR; end
    @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("job_timeout", 32'(busy), 32'd0);
  endtask

  logic [15:0] exp_cfg = 16'd0;
  bit          exp_rej = 1'b0;
  int          last_cyc = 0;

  task automatic run_job(input int d, input int e, input bit busy_wr, input logic [31:0] ctrl);
    logic [31:0] rd;
    logic        err;
    int          hi0, r0, ec;
    dly_hi = d; dly_lo = e;
    hi0 = start_hi_cyc; r0 = start_rises;
    if (ctrl[1]) exp_rej = 1'b0;
    apb_write(32'h0, ctrl, err);
    check("start_busy", 32'(busy), 32'd1);
    if (busy_wr) begin
      apb_write(32'h8, 32'h0000_0505, err);
      apb_write(32'h0, 32'h1, err);
      exp_rej = 1'b1;
    end
    wait_idle();
    ec = (d + e + 2 > CNT_MAX) ? CNT_MAX : d + e + 2;
    last_cyc = ec;
    check("start_high_cycles", 32'(start_hi_cyc - hi0), 32'(d + 1));
    check("start_rises", 32'(start_rises - r0), 32'd1);
    apb_read(32'h4, rd, err);
    check("job_status", rd, {29'd0, exp_rej, 2'b10});
    apb_read(32'hC, rd, err);
    check("job_cycles", rd, 32'(ec));
    apb_read(32'h8, rd, err);
    check("job_cfg", rd, {16'd0, exp_cfg});
    check("cfg_ports", {16'd0, cfg_channel, cfg_width}, {16'd0, exp_cfg});
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          hi0, r0;
    rstn = 1'b0; man_done = 1'b0;
    PADDR = '0; PWDATA = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pool_start", 32'(pool_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg", {16'd0, cfg_channel, cfg_width}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Configuration readback
    apb_write(32'h8, 32'h0000_0C1C, err);
    exp_cfg = 16'h0C1C;
    check("cfg_wr_err", 32'(err), 32'd0);
    apb_read(32'h8, rd, err);
    check("cfg_read", rd, 32'h0000_0C1C);
    check("cfg_width", 32'(cfg_width), 32'd28);
    check("cfg_channel", 32'(cfg_channel), 32'd12);
    apb_read(32'h4, rd, err);
    check("status_idle", rd, 32'd0);
    apb_read(32'h0, rd, err);
    check("ctrl_read", rd, 32'd0);
    check("ctrl_read_err", 32'(err), 32'd0);

    // Reference job, then one with writes attempted while busy
    run_job(10, 2, 1'b0, 32'h1);
    run_job(8, 1, 1'b1, 32'h1);
    apb_write(32'h0, 32'h2, err);
    exp_rej = 1'b0;
    apb_read(32'h4, rd, err);
    check("status_cleared", rd, 32'd0);

    // Back-to-back restart from DONE with start and clear together
    run_job(5, 1, 1'b0, 32'h1);
    dly_hi = 12; dly_lo = 1;
    hi0 = start_hi_cyc; r0 = start_rises;
    apb_write(32'h0, 32'h3, err);
    apb_read(32'hC, rd, err);
    check("b2b_cycles_restart", rd, 32'd1);
    apb_read(32'h4, rd, err);
    check("b2b_status_run", rd, 32'd1);
    wait_idle();
    check("b2b_rises", 32'(start_rises - r0), 32'd1);
    check("b2b_high_cycles", 32'(start_hi_cyc - hi0), 32'd13);
    apb_read(32'hC, rd, err);
    check("b2b_cycles", rd, 32'd15);
    last_cyc = 15;

    // pool_done while in DONE is ignored
    r0 = start_rises;
    man_done = 1'b1;
    repeat (3) @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    apb_read(32'h4, rd, err);
    check("done_in_done_status", rd, 32'h2);

    // Unmapped accesses and address aliasing above ADDR_W
    apb_write(32'h10, 32'h0000_0F03, err);
    check("unmapped_wr_err", 32'(err), 32'd1);
    apb_read(32'h10, rd, err);
    check("unmapped_rd_err", 32'(err), 32'd1);
    check("unmapped_rd_data", rd, 32'd0);
    apb_read(32'h4, rd, err);
    check("unmapped_no_effect", rd, 32'h2);
    check("unmapped_no_start", 32'(start_rises - r0), 32'd0);
    apb_write(32'h0, 32'h2, err);
    apb_write(32'h0001_0008, 32'h0000_3344, err);
    exp_cfg = 16'h3344;
    check("alias_wr_err", 32'(err), 32'd0);
    apb_read(32'h8, rd, err);
    check("alias_cfg", rd, 32'h0000_3344);

    // pool_done while IDLE is ignored
    r0 = start_rises;
    man_done = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_done_busy", 32'(busy), 32'd0);
    man_done = 1'b0;
    @(negedge clk);
    apb_read(32'h4, rd, err);
    check("idle_done_status", rd, 32'd0);
    apb_read(32'hC, rd, err);
    check("idle_cycles_frozen", rd, 32'(last_cyc));
    check("idle_done_no_start", 32'(start_rises - r0), 32'd0);

    // Counter saturation
    run_job(40, 3, 1'b0, 32'h1);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      int d, e;
      logic [15:0] c;
      d = $urandom_range(0, 34);
      e = $urandom_range(0, 4);
      c = 16'($urandom);
      apb_write(32'h8, {16'd0, c}, err);
      exp_cfg = c;
      run_job(d, e, (d >= 6) && ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1);
    end

    // Reset in the middle of a job
    apb_write(32'h0, 32'h2, err);
    exp_rej = 1'b0;
    dly_hi = 30; dly_lo = 1;
    apb_write(32'h0, 32'h1, err);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("rst_mid_pool_start", 32'(pool_start), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    r0 = start_rises;
    @(negedge clk);
    apb_read(32'h8, rd, err);
    check("rst_mid_cfg", rd, 32'd0);
    apb_read(32'hC, rd, err);
    check("rst_mid_cycles", rd, 32'd0);
    repeat (5) @(negedge clk);
    apb_read(32'h4, rd, err);
    check("rst_mid_status", rd, 32'd0);
    check("rst_mid_no_restart", 32'(start_rises - r0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
